// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: built-in self-test sequencer for a 3-in/3-out
// truth-table gate. It drives every input code 0..7 in order, waits
// SETTLE_CYCLES+1 cycles per code and samples the gate's output. Each
// sample is compared against a host-loaded expected table, and the
// observed words plus a per-row mismatch mask are reported.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        exp_wr,
  input  logic [2:0]  exp_addr,
  input  logic [2:0]  exp_data,
  output logic [2:0]  lut_in,
  input  logic [2:0]  lut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  mismatch_mask,
  output logic [23:0] captured
);

  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    FINISH
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [2:0] row;
  logic [2:0] exp_tbl [8];

  // Expected-table register file; host writes are only taken while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) begin
        exp_tbl[i] <= '0;
      end
    end else if (exp_wr && !busy) begin
      exp_tbl[exp_addr] <= exp_data;
    end
  end

  // Sweep sequencer: settle, sample, advance row, report on completion.
  // busy is low exactly when the sequencer sits in IDLE, so the table
  // write above and start acceptance below share the same gate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      row           <= '0;
      lut_in        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      mismatch_mask <= '0;
      captured      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            row           <= '0;
            lut_in        <= '0;
            cnt           <= CNT_RELOAD;
            mismatch_mask <= '0;
            captured      <= '0;
            pass          <= 1'b0;
            busy          <= 1'b1;
            state         <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        SAMPLE: begin
          for (int unsigned i = 0; i < 8; i++) begin
            if (row == 3'(i)) begin
              captured[3*i +: 3] <= lut_out;
            end
          end
          mismatch_mask[row] <= (lut_out != exp_tbl[row]);
          if (row == 3'd7) begin
            lut_in <= '0;
            state  <= FINISH;
          end else begin
            row    <= row + 3'd1;
            lut_in <= row + 3'd1;
            cnt    <= CNT_RELOAD;
            state  <= SETTLE;
          end
        end
        FINISH: begin
          done   <= 1'b1;
          busy   <= 1'b0;
          lut_in <= '0;
          pass   <= (mismatch_mask == '0);
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper. Instance A uses the default
// settle time with a combinational gate; instance B uses SETTLE_CYCLES=1
// with a gate that has one register of delay. A schedule-level model
// predicts every output on every cycle.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_s    [2];
  logic        exp_wr_s   [2];
  logic [2:0]  exp_addr_s [2];
  logic [2:0]  exp_data_s [2];

  logic [2:0]  lut_in_a, lut_in_b, lut_out_a, lut_out_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [7:0]  mask_a, mask_b;
  logic [23:0] cap_a, cap_b;

  logic [2:0]  gate_tbl [2][8];
  logic [2:0]  ref_rows [8] = '{3'b111, 3'b110, 3'b100, 3'b101,
                                3'b001, 3'b000, 3'b010, 3'b011};

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  truth_table_sweeper dut_a (
    .clk(clk), .rst(rst), .start(start_s[0]), .exp_wr(exp_wr_s[0]),
    .exp_addr(exp_addr_s[0]), .exp_data(exp_data_s[0]), .lut_in(lut_in_a),
    .lut_out(lut_out_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .mismatch_mask(mask_a), .captured(cap_a)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_s[1]), .exp_wr(exp_wr_s[1]),
    .exp_addr(exp_addr_s[1]), .exp_data(exp_data_s[1]), .lut_in(lut_in_b),
    .lut_out(lut_out_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .mismatch_mask(mask_b), .captured(cap_b)
  );

  // Gate models: A is purely combinational, B registers its output once.
  always_comb lut_out_a = gate_tbl[0][lut_in_a];
  always @(posedge clk) lut_out_b <= gate_tbl[1][lut_in_b];

  // ---------------- behavioural model ----------------
  // k = number of edges since the accepting edge (0 = accepting edge),
  // -1 when no sweep has been run or after the done cycle.
  int          k [2] = '{-1, -1};
  logic [2:0]  m_exp  [2][8];
  logic [23:0] m_cap  [2];
  logic [7:0]  m_mask [2];
  logic        m_pass [2];

  function automatic int period(input int i);
    return (i == 0) ? 3 : 2;
  endfunction

  // Row sampled at edge number n, or -1 if no sample happens there.
  function automatic int row_at(input int n, input int p);
    if (n >= p && n % p == 0 && n / p <= 8) return n / p - 1;
    return -1;
  endfunction

  function automatic bit m_busy(input int i);
    return k[i] >= 0 && k[i] <= 8 * period(i);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        k[i]      <= -1;
        m_cap[i]  <= '0;
        m_mask[i] <= '0;
        m_pass[i] <= 1'b0;
        for (int r = 0; r < 8; r++) m_exp[i][r] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_busy(i) && exp_wr_s[i]) m_exp[i][exp_addr_s[i]] <= exp_data_s[i];
        if (!m_busy(i) && start_s[i]) begin
          k[i]      <= 0;
          m_cap[i]  <= '0;
          m_mask[i] <= '0;
          m_pass[i] <= 1'b0;
        end else if (m_busy(i)) begin
          k[i] <= k[i] + 1;
          if (row_at(k[i] + 1, period(i)) >= 0) begin
            m_cap[i][3*row_at(k[i] + 1, period(i)) +: 3] <=
              gate_tbl[i][row_at(k[i] + 1, period(i))];
            m_mask[i][row_at(k[i] + 1, period(i))] <=
              (gate_tbl[i][row_at(k[i] + 1, period(i))] !=
               m_exp[i][row_at(k[i] + 1, period(i))]);
          end
          if (k[i] + 1 == 8 * period(i) + 1) m_pass[i] <= (m_mask[i] == '0);
        end else begin
          k[i] <= -1;
        end
      end
    end
  end

  function automatic logic [2:0] p_lut(input int i);
    if (k[i] >= 0 && k[i] < 8 * period(i)) return 3'(k[i] / period(i));
    return 3'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("busy_a", 32'(busy_a), 32'(m_busy(0)));
    chk("done_a", 32'(done_a), 32'(k[0] == 8 * period(0) + 1));
    chk("lut_in_a", 32'(lut_in_a), 32'(p_lut(0)));
    chk("pass_a", 32'(pass_a), 32'(m_pass[0]));
    chk("mask_a", 32'(mask_a), 32'(m_mask[0]));
    chk("cap_a", 32'(cap_a), 32'(m_cap[0]));
    chk("busy_b", 32'(busy_b), 32'(m_busy(1)));
    chk("done_b", 32'(done_b), 32'(k[1] == 8 * period(1) + 1));
    chk("lut_in_b", 32'(lut_in_b), 32'(p_lut(1)));
    chk("pass_b", 32'(pass_b), 32'(m_pass[1]));
    chk("mask_b", 32'(mask_b), 32'(m_mask[1]));
    chk("cap_b", 32'(cap_b), 32'(m_cap[1]));
  end

  // ---------------- stimulus ----------------
  function automatic logic done_of(input int i);
    return (i == 0) ? done_a : done_b;
  endfunction

  // Starts instance i (any exp_wr already set lands in the same cycle) and
  // returns the number of edges from the accepting edge until done is seen.
  // poke: 0 none, 1 start+write row0=000 at cycle 5, 2 random pokes.
  task automatic run_sweep(input int i, input int poke, output int n);
    start_s[i] = 1'b1;
    @(negedge clk);
    start_s[i] = 1'b0;
    exp_wr_s[i] = 1'b0;
    n = 0;
    while (n < 200 && !done_of(i)) begin
      if ((poke == 1 && n == 5) || (poke == 2 && n % 3 == 1)) begin
        start_s[i]    = 1'b1;
        exp_wr_s[i]   = 1'b1;
        exp_addr_s[i] = (poke == 1) ? 3'd0 : 3'($urandom);
        exp_data_s[i] = (poke == 1) ? 3'd0 : 3'($urandom);
      end
      @(negedge clk);
      start_s[i]  = 1'b0;
      exp_wr_s[i] = 1'b0;
      n++;
    end
    chk($sformatf("sweep_timeout[%0d]", i), 32'(done_of(i)), 32'd1);
  endtask

  task automatic load_table(input int i);
    for (int r = 0; r < 8; r++) begin
      exp_wr_s[i]   = 1'b1;
      exp_addr_s[i] = 3'(r);
      exp_data_s[i] = ref_rows[r];
      gate_tbl[i][r] = ref_rows[r];
      @(negedge clk);
    end
    exp_wr_s[i] = 1'b0;
  endtask

  task automatic idle_count_done(input int i, input int cycles, output int d);
    d = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (done_of(i)) d++;
    end
  endtask

  initial begin
    int n;
    int d;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; exp_wr_s[i] = 1'b0;
      exp_addr_s[i] = '0; exp_data_s[i] = '0;
      for (int r = 0; r < 8; r++) gate_tbl[i][r] = '0;
    end
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    chk("rst_mask", 32'(mask_a), 32'd0);
    chk("rst_cap", 32'(cap_a), 32'd0);
    chk("rst_lut_in", 32'(lut_in_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reference gate, instance A, default settle.
    load_table(0);
    load_table(1);
    run_sweep(0, 0, n);
    chk("t1_latency", 32'(n), 32'd25);
    chk("t1_pass", 32'(pass_a), 32'd1);
    chk("t1_mask", 32'(mask_a), 32'h00);
    chk("t1_cap", 32'(cap_a), 32'h681B37);

    // Row 5 forced to 001.
    gate_tbl[0][5] = 3'b001;
    run_sweep(0, 0, n);
    chk("t2_latency", 32'(n), 32'd25);
    chk("t2_pass", 32'(pass_a), 32'd0);
    chk("t2_mask", 32'(mask_a), 32'h20);
    chk("t2_cap", 32'(cap_a), 32'h689B37);
    chk("t2_row5", 32'(cap_a[17:15]), 32'd1);
    gate_tbl[0][5] = ref_rows[5];

    // Registered gate with a single settle cycle.
    run_sweep(1, 0, n);
    chk("t3_latency", 32'(n), 32'd17);
    chk("t3_pass", 32'(pass_b), 32'd1);
    chk("t3_cap", 32'(cap_b), 32'h681B37);

    // Start and table write while busy are dropped.
    run_sweep(0, 1, n);
    chk("t4_latency", 32'(n), 32'd25);
    chk("t4_pass", 32'(pass_a), 32'd1);
    idle_count_done(0, 30, d);
    chk("t4_extra_done", 32'(d), 32'd0);

    // Randomized tables, gate faults, coincident writes and busy pokes.
    for (int it = 0; it < 8; it++) begin
      int i;
      i = it % 2;
      for (int r = 0; r < 8; r++) begin
        exp_wr_s[i]   = 1'b1;
        exp_addr_s[i] = 3'(r);
        exp_data_s[i] = 3'($urandom);
        gate_tbl[i][r] = ($urandom_range(0, 3) == 0) ? 3'($urandom) : exp_data_s[i];
        @(negedge clk);
      end
      exp_wr_s[i]   = 1'($urandom);
      exp_addr_s[i] = 3'($urandom);
      exp_data_s[i] = 3'($urandom);
      run_sweep(i, 2, n);
      chk($sformatf("rand_latency[%0d]", it), 32'(n), (i == 0) ? 32'd25 : 32'd17);
      @(negedge clk);
    end

    // Asynchronous reset mid-sweep while lut_in = 3.
    for (int r = 0; r < 8; r++) gate_tbl[0][r] = ref_rows[r];
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    n = 0;
    while (lut_in_a != 3'd3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_row3", 32'(lut_in_a), 32'd3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy_a), 32'd0);
    chk("t5_done", 32'(done_a), 32'd0);
    chk("t5_lut_in", 32'(lut_in_a), 32'd0);
    chk("t5_cap", 32'(cap_a), 32'd0);
    chk("t5_mask", 32'(mask_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_count_done(0, 30, d);
    chk("t5_no_done", 32'(d), 32'd0);
    run_sweep(0, 0, n);
    chk("t5_latency", 32'(n), 32'd25);
    chk("t5_pass", 32'(pass_a), 32'd0);
    chk("t5_mask_cleared_tbl", 32'(mask_a), 32'hDF);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer that exhaustively exercises a 3-input/3-output combinational logic block (a truth-table gate as emitted by netlist synthesis) by driving all 8 input codes in order. It captures each output word and checks it against a programmable expected truth table. Sits beside the synthesized gate as its built-in self-test controller: host loads expected rows, pulses start, reads pass/mismatch/captured results.

## Interface
- SETTLE_CYCLES, default 2: cycles lut_in is held before sampling lut_out (legal range 1..15).

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin sweep; accepted only in IDLE
- exp_wr  in  1  write expected row; accepted only when busy=0
- exp_addr  in  3  expected-table row (= input code)
- exp_data  in  3  expected {out1,out2,out3} for that row
- lut_in  out  3  {in1,in2,in3} driven to the logic block
- lut_out  in  3  {out1,out2,out3} returned from the logic block
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse, sweep complete
- pass  out  1  last sweep had zero mismatches
- mismatch_mask  out  8  bit i set if row i mismatched
- captured  out  24  observed outputs, row i at bits [3i+2:3i]

## Operation
- Expected table: 8×3 register file, written synchronously when exp_wr=1 and busy=0; writes while busy=1 are dropped.
- FSM states: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE: lut_in=0, busy=0. On start=1: row<=0, lut_in<=0, cnt<=SETTLE_CYCLES-1, mismatch_mask<=0, captured<=0, pass<=0, busy<=1, go SETTLE.
- SETTLE: hold lut_in; cnt decrements each cycle; when cnt==0 go SAMPLE.
- SAMPLE: on exit edge captured[row]<=lut_out; mismatch_mask[row]<=(lut_out!=exp[row]). If row==7 go FINISH; else row<=row+1, lut_in<=row+1, cnt<=SETTLE_CYCLES-1, go SETTLE.
- FINISH: done=1, busy=0, lut_in=0, pass=(mismatch_mask==0); go IDLE next cycle. start in FINISH is ignored.
- start while busy=1 or in FINISH: ignored, no effect on counters.
- Row counter is 3 bits; no wrap beyond 7, since termination is on row==7 in SAMPLE.
- mismatch_mask, captured and pass hold until the next accepted start.

## Timing
- Reset (async, immediate): state=IDLE, lut_in=0, busy=0, done=0, pass=0, mismatch_mask=0, captured=0, cnt=0, row=0, expected table all 0.
- Reset mid-sweep aborts the sweep; no done pulse; all results cleared.
- All outputs registered.
- lut_in changes on the edge entering SETTLE and is stable for SETTLE_CYCLES+1 cycles; lut_out is sampled at the end of that window.
- Per row: SETTLE_CYCLES+1 cycles. done asserts 8×(SETTLE_CYCLES+1)+1 cycles after the edge accepting start, i.e. 25 cycles for the default.
- busy rises the cycle after start is accepted and falls the same cycle done rises.
- exp_wr in the same cycle as an accepted start: the write lands, and the sweep uses the new value.

## Test plan
- Load expected rows 0..7 = 111,110,100,101,001,000,010,011. Attach a behavioral model of that gate and start -> done after 25 cycles, pass=1, mismatch_mask=0x00, captured = concatenation of the rows.
- Same setup with the model forcing row 5 output to 001 -> pass=0, mismatch_mask=0x20, captured[17:15]=001.
- SETTLE_CYCLES=1 with a model that adds 1 register of delay -> pass=1. The same model with zero settle margin (check that lut_in is held 2 cycles) -> sampling occurs on the 2nd cycle of each row.
- Pulse start and exp_wr (row 0 = 000) while busy -> no restart, expected table unchanged, done occurs exactly once at cycle 25.
- Assert rst while lut_in=3 -> all outputs 0 immediately, no done; a fresh start afterward runs a full 25-cycle sweep against the cleared table (all-zero expected).
- Reset values: after rst, before any clock -> busy=0, done=0, pass=0, mismatch_mask=0, captured=0, lut_in=0.
